// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: queues single-beat read/write commands and
// returns one response per bus transaction. Optional watchdog: WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int WB_ADDRESS_WIDTH = 32,
  parameter int WB_DATA_WIDTH    = 32,
  parameter int CMD_DEPTH        = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [WB_ADDRESS_WIDTH-1:0]   cmd_adr,
  input  logic [WB_DATA_WIDTH-1:0]      cmd_dat,
  input  logic [WB_DATA_WIDTH/8-1:0]    cmd_sel,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]      rsp_dat,
  output logic                          rsp_err,
  output logic                          wb_cyc,
  output logic                          wb_stb,
  output logic                          wb_we,
  output logic [WB_ADDRESS_WIDTH-1:0]   wb_adr,
  output logic [WB_DATA_WIDTH-1:0]      wb_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0]    wb_sel,
  input  logic [WB_DATA_WIDTH-1:0]      wb_dat_r,
  input  logic                          wb_ack,
  input  logic                          wb_err,
  output logic                          busy
);

  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int AW = $clog2(CMD_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic                        r_memWe  [CMD_DEPTH];
  logic [WB_ADDRESS_WIDTH-1:0] r_memAdr [CMD_DEPTH];
  logic [WB_DATA_WIDTH-1:0]    r_memDat [CMD_DEPTH];
  logic [SW-1:0]               r_memSel [CMD_DEPTH];

  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic [AW:0] w_wrPtrNext;
  logic [AW:0] w_rdPtrNext;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_fullNext;
  logic        r_cmdReady;

  logic                        r_wbCyc;
  logic                        r_wbStb;
  logic                        r_wbWe;
  logic [WB_ADDRESS_WIDTH-1:0] r_wbAdr;
  logic [WB_DATA_WIDTH-1:0]    r_wbDat;
  logic [SW-1:0]               r_wbSel;
  logic                        r_rspValid;
  logic [WB_DATA_WIDTH-1:0]    r_rspDat;
  logic                        r_rspErr;

  logic                        w_wbCycNext;
  logic                        w_wbStbNext;
  logic                        w_wbWeNext;
  logic [WB_ADDRESS_WIDTH-1:0] w_wbAdrNext;
  logic [WB_DATA_WIDTH-1:0]    w_wbDatNext;
  logic [SW-1:0]               w_wbSelNext;
  logic                        w_rspValidNext;
  logic [WB_DATA_WIDTH-1:0]    w_rspDatNext;
  logic                        w_rspErrNext;
  logic                        w_load;
  logic                        w_timeout;
  logic                        w_done;

  assign w_push      = cmd_valid && r_cmdReady;
  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_wrPtrNext = r_wrPtr + {{AW{1'b0}}, w_push};
  assign w_rdPtrNext = r_rdPtr + {{AW{1'b0}}, w_pop};
  // cmd_ready is registered from the post-edge occupancy so it never depends on cmd_valid.
  assign w_fullNext  = (w_wrPtrNext[AW] != w_rdPtrNext[AW]) &&
                       (w_wrPtrNext[AW-1:0] == w_rdPtrNext[AW-1:0]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memWe[r_wrPtr[AW-1:0]]  <= cmd_we;
      r_memAdr[r_wrPtr[AW-1:0]] <= cmd_adr;
      r_memDat[r_wrPtr[AW-1:0]] <= cmd_dat;
      r_memSel[r_wrPtr[AW-1:0]] <= cmd_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_cmdReady <= 1'b0;
    end else begin
      r_wrPtr    <= w_wrPtrNext;
      r_rdPtr    <= w_rdPtrNext;
      r_cmdReady <= !w_fullNext;
    end
  end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0] r_toCnt;

  // Counter reads k-1 at the k-th BUS edge, so the bus is held exactly TIMEOUT_CYCLES cycles.
  assign w_timeout = (r_state == S_BUS) && !wb_ack && !wb_err &&
                     (r_toCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toCnt <= '0;
    end else if (w_load) begin
      r_toCnt <= '0;
    end else if ((r_state == S_BUS) && !wb_ack && !wb_err) begin
      r_toCnt <= r_toCnt + TW'(1);
    end
  end
`else
  // Never true for a legal TIMEOUT_CYCLES: without the watchdog the bus waits indefinitely.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign w_done = wb_ack || wb_err || w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_load         = 1'b0;
    w_pop          = 1'b0;
    w_wbCycNext    = r_wbCyc;
    w_wbStbNext    = r_wbStb;
    w_wbWeNext     = r_wbWe;
    w_wbAdrNext    = r_wbAdr;
    w_wbDatNext    = r_wbDat;
    w_wbSelNext    = r_wbSel;
    w_rspValidNext = r_rspValid;
    w_rspDatNext   = r_rspDat;
    w_rspErrNext   = r_rspErr;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_stateNext = S_BUS;
        end
      end
      S_BUS: begin
        if (w_done) begin
          w_wbCycNext    = 1'b0;
          w_wbStbNext    = 1'b0;
          w_wbWeNext     = 1'b0;
          w_wbAdrNext    = '0;
          w_wbDatNext    = '0;
          w_wbSelNext    = '0;
          w_rspValidNext = 1'b1;
          // Simultaneous ack+err and a timeout both count as errors with no data.
          w_rspErrNext   = wb_err || !wb_ack;
          w_rspDatNext   = (!r_wbWe && wb_ack && !wb_err) ? wb_dat_r : '0;
          w_stateNext    = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_rspValidNext = 1'b0;
          w_rspDatNext   = '0;
          w_rspErrNext   = 1'b0;
          if (!w_empty) begin
            w_load      = 1'b1;
            w_stateNext = S_BUS;
          end else begin
            w_stateNext = S_IDLE;
          end
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_pop       = 1'b1;
      w_wbCycNext = 1'b1;
      w_wbStbNext = 1'b1;
      w_wbWeNext  = r_memWe[r_rdPtr[AW-1:0]];
      w_wbAdrNext = r_memAdr[r_rdPtr[AW-1:0]];
      w_wbDatNext = r_memDat[r_rdPtr[AW-1:0]];
      w_wbSelNext = r_memSel[r_rdPtr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbCyc    <= 1'b0;
      r_wbStb    <= 1'b0;
      r_wbWe     <= 1'b0;
      r_wbAdr    <= '0;
      r_wbDat    <= '0;
      r_wbSel    <= '0;
      r_rspValid <= 1'b0;
      r_rspDat   <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      r_wbCyc    <= w_wbCycNext;
      r_wbStb    <= w_wbStbNext;
      r_wbWe     <= w_wbWeNext;
      r_wbAdr    <= w_wbAdrNext;
      r_wbDat    <= w_wbDatNext;
      r_wbSel    <= w_wbSelNext;
      r_rspValid <= w_rspValidNext;
      r_rspDat   <= w_rspDatNext;
      r_rspErr   <= w_rspErrNext;
    end
  end

  assign cmd_ready = r_cmdReady;
  assign wb_cyc    = r_wbCyc;
  assign wb_stb    = r_wbStb;
  assign wb_we     = r_wbWe;
  assign wb_adr    = r_wbAdr;
  assign wb_dat_w  = r_wbDat;
  assign wb_sel    = r_wbSel;
  assign rsp_valid = r_rspValid;
  assign rsp_dat   = r_rspDat;
  assign rsp_err   = r_rspErr;
  assign busy      = !w_empty || (r_state != S_IDLE);

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic-cycle initiator: the bus-master counterpart to the team's Wishbone SRAM slave.
- Accepts single-beat read/write commands on a valid/ready port and buffers them in a small command FIFO.
- Issues one Wishbone transaction at a time and returns each completion (read data, error flag) on a valid/ready response port.
- Used by test infrastructure and simple controllers to drive wb_sram and other slaves on the system bus.

Parameters:
WB_ADDRESS_WIDTH, 32, width of wb_adr and cmd_adr
WB_DATA_WIDTH, 32, data width; multiple of 8
CMD_DEPTH, 4, command FIFO entries; power of 2, >=2
TIMEOUT_CYCLES, 255, bus cycles to wait for ack/err before forced termination (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_we  in  1  1=write, 0=read
cmd_adr  in  WB_ADDRESS_WIDTH  byte address
cmd_dat  in  WB_DATA_WIDTH  write data
cmd_sel  in  WB_DATA_WIDTH/8  byte enables
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
rsp_dat  out  WB_DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  transaction terminated by error (or timeout)
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  Wishbone write enable
wb_adr  out  WB_ADDRESS_WIDTH  Wishbone address
wb_dat_w  out  WB_DATA_WIDTH  Wishbone write data
wb_sel  out  WB_DATA_WIDTH/8  Wishbone byte select
wb_dat_r  in  WB_DATA_WIDTH  Wishbone read data
wb_ack  in  1  Wishbone acknowledge
wb_err  in  1  Wishbone error
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0 except cmd_ready; FIFO emptied; FSM=IDLE. cmd_ready is 0 while rst is high and 1 on the first cycle after release.
- Reset asserted mid-transaction drops wb_cyc/wb_stb immediately. The in-flight command and any pending response are discarded.
- Command FIFO:
  - cmd_ready = !full; registered and output-independent of cmd_valid.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - Pointers are log2(CMD_DEPTH)+1 bits and wrap naturally.
- FSM states: IDLE, BUS, RSP. All wb_* outputs are registered.
- IDLE:
  - If FIFO non-empty at an edge: pop head, load wb_adr/wb_dat_w/wb_sel/wb_we, assert wb_cyc=wb_stb=1, go BUS.
  - Minimum latency: command accepted at edge k into an empty FIFO -> wb_cyc rises at edge k+1.
- BUS:
  - All wb_* outputs held stable.
  - At the first edge where wb_ack or wb_err is sampled high: wb_cyc=wb_stb=0; rsp_valid=1; rsp_err=wb_err; go RSP.
  - rsp_dat = wb_dat_r for a read with ack; 0 otherwise.
  - wb_ack and wb_err both high: treated as error (rsp_err=1, rsp_dat=0).
- RSP:
  - rsp_valid, rsp_dat and rsp_err held until handshake.
  - On handshake with FIFO non-empty: go BUS directly, loading the next command. wb_cyc is therefore low for at least one cycle between transactions.
  - On handshake with FIFO empty: rsp_valid=0, go IDLE.
- Only one outstanding transaction. Commands complete and return strictly in order.
- wb_sel/wb_adr/wb_dat_w are returned to 0 when wb_cyc drops.

Optional Feature:
- Macro: WB_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES with no ack/err, the cycle is terminated as if wb_err was sampled: rsp_err=1, rsp_dat=0, go RSP.
  - An ack/err arriving on the same edge as the timeout takes precedence.
- Not defined: no counter; BUS waits indefinitely; TIMEOUT_CYCLES ignored.

Test Plan:
- Write adr=0x10, dat=0xDEADBEEF, sel=0xF; slave acks 2 cycles after stb -> wb_cyc high exactly 3 cycles, wb_we=1, rsp_valid with rsp_err=0, rsp_dat=0.
- Read adr=0x10 after that write to wb_sram, rsp_ready held high -> rsp_dat=0xDEADBEEF; wb_cyc rises 1 cycle after cmd accept.
- Push 5 commands with rsp_ready=0 (CMD_DEPTH=4) -> cmd_ready drops after the FIFO fills. The 1st transaction completes and holds in RSP; no second wb_cyc until rsp_ready=1. All 5 responses return in order.
- Slave asserts wb_err on a read -> rsp_err=1, rsp_dat=0. The next queued command still issues normally.
- rst pulsed while wb_cyc=1 -> wb_cyc, rsp_valid and busy go 0 asynchronously; FIFO empty; cmd_ready=1 the cycle after release.
- With WB_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> wb_cyc drops after 8 BUS cycles, rsp_err=1. Without the macro, wb_cyc stays high.
